// File: rtl/vedic_mul_pkg.sv
// vedic_mul_pkg: shared widths, arbiter state encoding and tag-width helper
package vedic_mul_pkg;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  typedef enum logic {RUN, DRAIN} arb_state_t;
  function automatic int clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vedic_tag_fifo.sv
// vedic_tag_fifo: in-order tag FIFO; a push while full is accepted only alongside a pop
module vedic_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int TW = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [TW-1:0]          din,
  output logic [TW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/vedic_mul_arbiter.sv
// vedic_mul_arbiter: round-robin front end sharing one vedic8x8 multiplier among NREQ requesters.
// Define VEDIC_MUL_ARB_STATS_EN to add the per-requester saturating accept counters (stat_cnt).
module vedic_mul_arbiter
  import vedic_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*OP_W-1:0]   req_a,
  input  logic [NREQ*OP_W-1:0]   req_b,
  output logic [NREQ-1:0]        gnt,
  input  logic                   flush,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  output logic                   mul_start,
  input  logic [PROD_W-1:0]      mul_result,
  input  logic                   mul_done,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]      rsp_data,
  output logic                   busy,
  output logic                   err
`ifdef VEDIC_MUL_ARB_STATS_EN
  , output logic [NREQ*16-1:0]   stat_cnt
`endif
);
  localparam int TW = clog2(NREQ);
  arb_state_t state, state_next;
  logic [TW-1:0] rr_ptr, gidx, head;
  logic [NREQ-1:0] pick;
  logic [$clog2(DEPTH):0] count;
  logic full, empty, accept, pop, grant_en;
  assign pop = mul_done & ~empty;
  assign grant_en = ~reset & (state == RUN) & (~full | mul_done);
  // scanning downward leaves the first requester at or after rr_ptr as the winner
  always_comb begin
    int j;
    pick = '0;
    gidx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      j = j >= NREQ ? j - NREQ : j;
      if (req[j]) begin
        pick = NREQ'(1) << j;
        gidx = TW'(j);
      end
    end
  end
  assign gnt = grant_en ? pick : '0;
  assign accept = |gnt;
  assign busy = (count != '0) | (state == DRAIN);
  vedic_tag_fifo #(.DEPTH(DEPTH), .TW(TW)) u_fifo (
    .clk(clk), .reset(reset), .push(accept), .pop(pop), .din(gidx),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_comb state_next = state == RUN ? (flush ? DRAIN : RUN) : ((count == '0 && !flush) ? RUN : DRAIN);
  always_ff @(posedge clk) state <= reset ? RUN : state_next;
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_start <= 1'b0;
      rsp_valid <= '0;
      rsp_data <= '0;
      err <= 1'b0;
    end else begin
      mul_start <= accept;
      rsp_valid <= pop ? NREQ'(1) << head : '0;
      err <= err | (mul_done & empty);
      if (pop) rsp_data <= mul_result;
      if (accept) begin
        mul_a <= req_a[gidx*OP_W +: OP_W];
        mul_b <= req_b[gidx*OP_W +: OP_W];
        rr_ptr <= gidx == TW'(NREQ - 1) ? '0 : gidx + TW'(1);
      end
    end
  end
`ifdef VEDIC_MUL_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    always_ff @(posedge clk) begin
      if (reset) stat_cnt[i*16 +: 16] <= '0;
      else if (gnt[i] && stat_cnt[i*16 +: 16] != 16'hFFFF) stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif
endmodule
